s_axis_ppf_interp: RTL
======================

# s_axis_ppf_interp

Polyphase interpolating FIR for AXI-Stream sample paths, the synthesis-direction counterpart of the direct-form decimating polyphase filter bank. For each accepted input sample it produces L output samples, one per polyphase branch. Each output is computed by a single time-multiplexed multiply-accumulate over TAPS coefficients. It sits between a baseband AXI-Stream source and the higher-rate output stream.

## Interface
- L, 4, interpolation factor (number of phases, ≥2)
- TAPS, 4, taps per phase (total coefficients L*TAPS)
- DWIDTH, 16, signed input sample width
- CWIDTH, 16, signed coefficient width
- OWIDTH, 34, signed output width; must be ≥ DWIDTH+CWIDTH+clog2(TAPS)
- clk_i  in  1  single clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- s_axis_tdata  in  DWIDTH  input sample (signed)
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  OWIDTH  output sample (signed, full precision)
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  high on phase L-1 output
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(L*TAPS)  coefficient index i
- coef_data  in  CWIDTH  coefficient value h[i] (signed)

## Operation
- Delay line x[0..TAPS-1], x[0] newest. On an input handshake: shift x[k]←x[k-1] and load x[0]←s_axis_tdata.
- Phase p output: y_p = Σ_{k=0..TAPS-1} h[k*L+p]·x[k]. Full-precision sign-extended sum. No rounding, no saturation.
- FSM:
  - IDLE: s_axis_tready=1. On handshake: shift, set p=0, k=0, go to MAC.
  - MAC: one product per cycle, k=0..TAPS-1. At k=0, acc←product (clear). Otherwise acc←acc+product. After k=TAPS-1, go to OUT.
  - OUT: m_axis_tvalid=1, m_axis_tdata=acc, m_axis_tlast=(p==L-1). On handshake: if p==L-1, go to IDLE; else p←p+1, k←0, go to MAC.
- s_axis_tready = (state==IDLE), decoded directly from the state register.
- Coefficient writes take effect only in IDLE. coef_we outside IDLE is ignored. A write in cycle c is visible to a MAC that starts at c+1.
- Reset (async, any state): state IDLE, p=k=0, delay line 0, all coefficients 0, acc 0. An in-flight output is discarded.

## Timing
- Reset values: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
- Input handshake at cycle t: MAC occupies t+1..t+TAPS. m_axis_tvalid rises at t+TAPS+1.
- OUT handshake at cycle c (p<L-1): next tvalid at c+TAPS+1. tvalid is low between phase outputs.
- Throughput with tready held high: one output per TAPS+1 cycles. One input is accepted per L·(TAPS+1)+1 cycles.
- Backpressure: in OUT, tdata, tlast and tvalid hold stable until m_axis_tready. s_axis_tready stays 0 throughout.
- After the phase L-1 handshake at cycle c, s_axis_tready=1 at c+1.

## Structure
- Shared package/include ppf_interp_pkg holds:
  - state encoding (IDLE, MAC, OUT)
  - clog2 helper
  - OWIDTH legality check constant, used by an elaboration assertion
- Sub-module ppf_mac: registered signed multiply-accumulate with clear input (acc←clr ? a·b : acc+a·b), async active-low reset.
- Top level holds the FSM, the p/k counters, the delay line, the coefficient register array and the coefficient mux (index k*L+p).

## Test plan
1. Impulse response. Params L=4, TAPS=4, h[i]=i+1 for i=0..15. Drive input 1 then 0,0,0. Required: outputs 1,2,…,16 in order, tlast on 4, 8, 12 and 16.
2. DC gain. All h=1, input constant 100. Required: from the 4th input onward every output is 400; first-input outputs are 100.
3. Backpressure. Hold m_axis_tready=0 for 10 cycles in OUT. Required: tvalid, tdata and tlast stable; s_axis_tready=0; no lost or duplicated output. Release, then check the next tvalid comes TAPS+1 cycles after the handshake.
4. Extremes. All h=-32768, four inputs of -32768. Required: outputs equal 4294967296 exactly, with no wrap in 34 bits.
5. Coefficient write gating. Write h[0]=7 during MAC: ignored, outputs unchanged. Write it again in IDLE: the next impulse produces 7 as the first output.
6. Reset mid-MAC. Assert rstn_i during the 2nd MAC cycle. Required: immediately tvalid=0 and tready=1. With all coefficients reloaded to 1, the next input 5 yields outputs of 5 (history cleared).

Source files
------------

// File: rtl/ppf_interp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ppf_interp_pkg                                              |
// | Brief  : Shared state encoding and elaboration helpers for the       |
// |          polyphase interpolating FIR.                                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package ppf_interp_pkg;

  // FSM state encoding
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_mac  = 2'd1;
  localparam logic [1:0] c_st_out  = 2'd2;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int ppf_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Output width must hold the full-precision sum of TAPS products
  function automatic bit ppf_owidth_ok(input int dw, input int cw, input int ow, input int taps);
    return ow >= (dw + cw + ppf_clog2(taps));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppf_mac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ppf_mac                                                     |
// | Brief  : Registered signed multiply-accumulate with clear.           |
// |          acc <= clr ? a*b : acc + a*b  (when enabled)                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ppf_mac
  import ppf_interp_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 16,
  parameter int OWIDTH = 34
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [AWIDTH-1:0] i_a,
  input  logic [BWIDTH-1:0] i_b,
  output logic [OWIDTH-1:0] o_acc
);

  logic signed [OWIDTH-1:0] w_a_ext;
  logic signed [OWIDTH-1:0] w_b_ext;
  logic signed [OWIDTH-1:0] w_prod;
  logic signed [OWIDTH-1:0] r_acc;

  // Operands are sign-extended to the accumulator width so the product is exact
  assign w_a_ext = OWIDTH'($signed(i_a));
  assign w_b_ext = OWIDTH'($signed(i_b));
  assign w_prod  = w_a_ext * w_b_ext;

  // Accumulator: clear loads the first product of a new sum
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_clr ? w_prod : (r_acc + w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/s_axis_ppf_interp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : s_axis_ppf_interp                                           |
// | Brief  : Polyphase interpolating FIR, AXI-Stream in/out. Each input  |
// |          sample yields L outputs, one per phase, each computed by a  |
// |          single time-multiplexed MAC over TAPS coefficients.         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module s_axis_ppf_interp
  import ppf_interp_pkg::*;
#(
  parameter int L      = 4,
  parameter int TAPS   = 4,
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int OWIDTH = 34
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [DWIDTH-1:0]             s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [OWIDTH-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic                          coef_we,
  input  logic [ppf_clog2(L*TAPS)-1:0]  coef_addr,
  input  logic [CWIDTH-1:0]             coef_data
);

  localparam int c_nc = L * TAPS;
  localparam int c_aw = ppf_clog2(c_nc);
  localparam int c_pw = (ppf_clog2(L) < 1) ? 1 : ppf_clog2(L);
  localparam int c_kw = (ppf_clog2(TAPS) < 1) ? 1 : ppf_clog2(TAPS);
  localparam bit c_owidth_ok = ppf_owidth_ok(DWIDTH, CWIDTH, OWIDTH, TAPS);

  if (!c_owidth_ok) begin : g_owidth_check
    $error("s_axis_ppf_interp: OWIDTH too narrow for full-precision sum");
  end

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [c_pw-1:0]   r_phase;
  logic [c_kw-1:0]   r_tap;
  logic [DWIDTH-1:0] r_x    [TAPS];
  logic [CWIDTH-1:0] r_coef [c_nc];
  logic              w_in_hs;
  logic              w_tap_last;
  logic              w_phase_last;
  logic              w_mac_en;
  logic              w_mac_clr;
  logic [c_aw-1:0]   w_coef_idx;
  logic [DWIDTH-1:0] w_mac_a;
  logic [CWIDTH-1:0] w_mac_b;

  assign w_in_hs      = s_axis_tvalid && (r_state == c_st_idle);
  assign w_tap_last   = (r_tap == c_kw'(TAPS - 1));
  assign w_phase_last = (r_phase == c_pw'(L - 1));

  // Coefficient for tap k of phase p lives at k*L+p
  assign w_coef_idx = c_aw'(int'(r_tap) * L + int'(r_phase));
  assign w_mac_a    = r_x[r_tap];
  assign w_mac_b    = r_coef[w_coef_idx];

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (s_axis_tvalid) w_state_nxt = c_st_mac;
      c_st_mac:  if (w_tap_last)    w_state_nxt = c_st_out;
      c_st_out:  if (m_axis_tready) w_state_nxt = w_phase_last ? c_st_idle : c_st_mac;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // Outputs decoded straight from the state register
  always_comb begin
    s_axis_tready = (r_state == c_st_idle);
    m_axis_tvalid = (r_state == c_st_out);
    m_axis_tlast  = (r_state == c_st_out) && w_phase_last;
    w_mac_en      = (r_state == c_st_mac);
    w_mac_clr     = (r_tap == '0);
  end

  // Phase and tap counters
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_phase <= '0;
      r_tap   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (s_axis_tvalid) begin
            r_phase <= '0;
            r_tap   <= '0;
          end
        end
        c_st_mac: begin
          if (!w_tap_last) r_tap <= r_tap + 1'b1;
        end
        c_st_out: begin
          if (m_axis_tready) begin
            r_tap <= '0;
            if (!w_phase_last) r_phase <= r_phase + 1'b1;
          end
        end
        default: begin
          r_phase <= '0;
          r_tap   <= '0;
        end
      endcase
    end
  end

  // Delay line, x[0] newest, shifts once per accepted input
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
    end else if (w_in_hs) begin
      r_x[0] <= s_axis_tdata;
      for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
    end
  end

  // Coefficient store; writes only land while idle so a sum never sees a mixed set
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < c_nc; i++) r_coef[i] <= '0;
    end else if (coef_we && (r_state == c_st_idle)) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  ppf_mac #(
    .AWIDTH (DWIDTH),
    .BWIDTH (CWIDTH),
    .OWIDTH (OWIDTH)
  ) u_mac (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .i_en   (w_mac_en),
    .i_clr  (w_mac_clr),
    .i_a    (w_mac_a),
    .i_b    (w_mac_b),
    .o_acc  (m_axis_tdata)
  );

endmodule
`default_nettype wire
